// File: rtl/register_pkg.sv
// Shared constants and occupancy state encoding for the register reader.
package register_pkg;

  localparam int unsigned WIDTH_DEFAULT = 32;
  localparam int unsigned SEQ_W_DEFAULT = 8;
  localparam int unsigned CNT_W_DEFAULT = 16;

  // ONE covers every partially-filled occupancy when DEPTH > 2.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_state_e;

endpackage : register_pkg

// File: rtl/sync_fifo.sv
// Parameterized storage array with wrapping pointers and an occupancy count.
// Push/pop qualification is the caller's responsibility.
module sync_fifo #(
  parameter int unsigned WIDTH = 40,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [CW-1:0]    count_q;

  // Storage, pointers and occupancy; cleared together on reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_q   <= '{default: '0};
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= wdata;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata = mem_q[rptr_q];
  assign count = count_q;

endmodule : sync_fifo

// File: rtl/register_reader.sv
// Snoops register writes, queues each captured value with a sequence tag and
// hands it to a consumer over valid/ready; overflowing updates are counted.
module register_reader
  import register_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned SEQ_W = SEQ_W_DEFAULT,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [WIDTH-1:0] rdata,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [SEQ_W-1:0] out_seq,
  input  logic             out_ready,
  output logic             full,
  output logic [CNT_W-1:0] drop_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned FW = WIDTH + SEQ_W;

  occ_state_e       state_q, state_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CW-1:0]    fifo_count;
  logic [FW-1:0]    fifo_rdata;
  logic             push;
  logic             pop;

  // A full queue still accepts a push when the head leaves on the same edge.
  assign pop  = out_valid & out_ready;
  assign push = wr & ((state_q != FULL) | pop);

  // Occupancy state register plus sequence and drop counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= EMPTY;
      seq_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      drop_q  <= drop_d;
    end
  end

  // Next occupancy state; simultaneous push and pop leaves it unchanged.
  always_comb begin
    state_d = state_q;
    case ({push, pop})
      2'b10:   state_d = (fifo_count == CW'(DEPTH - 1)) ? FULL : ONE;
      2'b01:   state_d = (fifo_count == CW'(1)) ? EMPTY : ONE;
      default: state_d = state_q;
    endcase
  end

  // Tag advances only on accepted pushes; drops saturate at all-ones.
  always_comb begin
    seq_d  = seq_q;
    drop_d = drop_q;
    if (push) begin
      seq_d = seq_q + SEQ_W'(1);
    end
    if (wr && !push && (drop_q != {CNT_W{1'b1}})) begin
      drop_d = drop_q + CNT_W'(1);
    end
  end

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata ({rdata, seq_q}),
    .rdata (fifo_rdata),
    .count (fifo_count)
  );

  assign out_valid  = (state_q != EMPTY);
  assign full       = (state_q == FULL);
  assign out_data   = fifo_rdata[FW-1:SEQ_W];
  assign out_seq    = fifo_rdata[SEQ_W-1:0];
  assign drop_count = drop_q;

endmodule : register_reader
